// File: rtl/instr_fetch_pkg.sv
// Shared constants and address legality check for the multi-port instruction fetch memory.
package instr_fetch_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_NUM_RD     = 2;
  localparam int MAX_ADDR_WIDTH = 64;

  // An address is legal when it is word aligned and every bit above the word index is zero.
  // Callers zero-extend their address to MAX_ADDR_WIDTH, so the bits beyond the real port width are zero.
  function automatic logic addr_is_legal(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                         input int depth_log2);
    logic legal;
    legal = (addr[1:0] == 2'b00);
    for (int i = 2; i < MAX_ADDR_WIDTH; i++) begin
      if ((i >= depth_log2 + 2) && addr[i]) begin
        legal = 1'b0;
      end
    end
    return legal;
  endfunction

endpackage

// File: rtl/instr_fetch_rd_port.sv
// One read port: optional input register, legality check, write-first forwarding and output register.
module instr_fetch_rd_port import instr_fetch_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int IN_REG     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DEPTH_LOG2-1:0] mem_idx,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wr_commit,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err
);

  logic                      req_eff;
  logic [ADDR_WIDTH-1:0]     addr_eff;
  logic [MAX_ADDR_WIDTH-1:0] addr_ext;
  logic                      legal;
  logic                      fwd_hit;

  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  if (IN_REG != 0) begin : g_in_reg
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Next value of the input stage is simply the raw request.
    always_comb begin
      req_d  = rd_req;
      addr_d = rd_addr;
    end

    // Input stage register; cleared by reset so in-flight requests vanish.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        req_q  <= 1'b0;
        addr_q <= '0;
      end else begin
        req_q  <= req_d;
        addr_q <= addr_d;
      end
    end

    assign req_eff  = req_q;
    assign addr_eff = addr_q;
  end else begin : g_no_in_reg
    assign req_eff  = rd_req;
    assign addr_eff = rd_addr;
  end

  assign addr_ext = MAX_ADDR_WIDTH'(addr_eff);
  assign legal    = addr_is_legal(addr_ext, DEPTH_LOG2);
  assign mem_idx  = addr_eff[DEPTH_LOG2+1:2];
  assign fwd_hit  = wr_commit && (wr_idx == mem_idx);

  // Response selection: illegal reads return zero, a colliding write wins over the stored word, idle cycles hold.
  always_comb begin
    valid_d = req_eff;
    err_d   = err_q;
    data_d  = data_q;
    if (req_eff) begin
      err_d = !legal;
      if (!legal) begin
        data_d = '0;
      end else if (fwd_hit) begin
        data_d = wr_data;
      end else begin
        data_d = mem_data;
      end
    end
  end

  // Output register; reset forces a quiet, zeroed port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_err   = err_q;
  assign rd_data  = data_q;

endmodule

// File: rtl/instr_fetch_mp.sv
// Multi-port instruction memory: shared array and write path, NUM_RD independent pipelined read ports.
module instr_fetch_mp import instr_fetch_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int IN_REG     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                      wr_en_eff;
  logic [ADDR_WIDTH-1:0]     wr_addr_eff;
  logic [DATA_WIDTH-1:0]     wr_data_eff;
  logic [MAX_ADDR_WIDTH-1:0] wr_addr_ext;
  logic [DEPTH_LOG2-1:0]     wr_idx;
  logic                      wr_commit;

  logic [DEPTH_LOG2-1:0] port_idx [NUM_RD];
  logic [DATA_WIDTH-1:0] tap_data [NUM_RD];

  if (IN_REG != 0) begin : g_wr_reg
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    // The write is staged alongside the reads so same-cycle write/read meet at one access edge.
    always_comb begin
      wr_en_d   = wr_en;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
    end

    // Write input stage; reset drops a pending write.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_en_q   <= 1'b0;
        wr_addr_q <= '0;
        wr_data_q <= '0;
      end else begin
        wr_en_q   <= wr_en_d;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
      end
    end

    assign wr_en_eff   = wr_en_q;
    assign wr_addr_eff = wr_addr_q;
    assign wr_data_eff = wr_data_q;
  end else begin : g_wr_direct
    assign wr_en_eff   = wr_en;
    assign wr_addr_eff = wr_addr;
    assign wr_data_eff = wr_data;
  end

  assign wr_addr_ext = MAX_ADDR_WIDTH'(wr_addr_eff);
  assign wr_idx      = wr_addr_eff[DEPTH_LOG2+1:2];
  assign wr_commit   = wr_en_eff && !rst && addr_is_legal(wr_addr_ext, DEPTH_LOG2);

  // Memory array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_idx] <= wr_data_eff;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    assign tap_data[k] = mem[port_idx[k]];

    instr_fetch_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .IN_REG     (IN_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .rd_req    (rd_req[k]),
      .rd_addr   (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_idx   (port_idx[k]),
      .mem_data  (tap_data[k]),
      .wr_commit (wr_commit),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data_eff),
      .rd_valid  (rd_valid[k]),
      .rd_data   (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_err    (rd_err[k])
    );
  end

endmodule

// File: tb/tb_instr_fetch_mp.sv
// Directed bench: DUT A uses defaults (IN_REG=1, two ports), DUT B uses IN_REG=0 with four ports.
module tb_instr_fetch_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;

  logic [1:0]   req_a;
  logic [63:0]  addr_a;
  logic [1:0]   valid_a;
  logic [63:0]  data_a;
  logic [1:0]   err_a;

  logic [3:0]   req_b;
  logic [127:0] addr_b;
  logic [3:0]   valid_b;
  logic [127:0] data_b;
  logic [3:0]   err_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0]  exp_a;
  logic [127:0] exp_b;

  always #5 clk = ~clk;

  instr_fetch_mp u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (req_a),
    .rd_addr  (addr_a),
    .rd_valid (valid_a),
    .rd_data  (data_a),
    .rd_err   (err_a)
  );

  instr_fetch_mp #(.NUM_RD(4), .IN_REG(0)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (req_b),
    .rd_addr  (addr_b),
    .rd_valid (valid_b),
    .rd_data  (data_b),
    .rd_err   (err_b)
  );

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_a = '0; addr_a = '0; req_b = '0; addr_b = '0;
    tick(); tick();
    check_output("rst_valid_a", 128'(valid_a), 128'h0);
    check_output("rst_err_a",   128'(err_a),   128'h0);
    check_output("rst_data_a",  128'(data_a),  128'h0);
    check_output("rst_valid_b", 128'(valid_b), 128'h0);
    check_output("rst_err_b",   128'(err_b),   128'h0);
    check_output("rst_data_b",  data_b,        128'h0);
    rst = 1'b0;

    // Basic write then read of 0x10
    $display("[TB] basic write/read");
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h0000_0013;
    tick();
    wr_en = 1'b0;
    tick();
    req_a = 2'b01; addr_a[31:0] = 32'h10;
    req_b = 4'b0001; addr_b[31:0] = 32'h10;
    tick();
    req_a = '0; req_b = '0;
    check_output("basic_valid_b",  128'(valid_b), 128'h1);
    check_output("basic_data_b0",  128'(data_b[31:0]), 128'h13);
    check_output("basic_err_b",    128'(err_b), 128'h0);
    check_output("basic_early_a",  128'(valid_a), 128'h0);
    tick();
    check_output("basic_valid_a",  128'(valid_a), 128'h1);
    check_output("basic_data_a0",  128'(data_a[31:0]), 128'h13);
    check_output("basic_err_a",    128'(err_a), 128'h0);
    check_output("basic_pulse_b",  128'(valid_b), 128'h0);

    // Illegal reads: misaligned and out of range
    $display("[TB] illegal reads");
    req_a = 2'b11; addr_a = {32'h0000_1000, 32'h0000_0012};
    req_b = 4'b1111; addr_b = {32'h10, 32'h2, 32'h1000, 32'h12};
    tick();
    req_a = '0; req_b = '0;
    check_output("ill_valid_b", 128'(valid_b), 128'hF);
    check_output("ill_err_b",   128'(err_b),   128'h7);
    check_output("ill_data_b",  data_b, {32'h13, 96'h0});
    tick();
    check_output("ill_valid_a", 128'(valid_a), 128'h3);
    check_output("ill_err_a",   128'(err_a),   128'h3);
    check_output("ill_data_a",  128'(data_a),  128'h0);

    // Write-first collision on 0x20, with an illegal aliasing write in between
    $display("[TB] collision");
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hAAAA_AAAA;
    tick();
    wr_addr = 32'h1010; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_addr = 32'h20; wr_data = 32'h5555_5555;
    req_a = 2'b11; addr_a = {2{32'h20}};
    req_b = 4'b1111; addr_b = {4{32'h20}};
    tick();
    wr_en = 1'b0; req_a = '0; req_b = '0;
    check_output("col_valid_b", 128'(valid_b), 128'hF);
    check_output("col_data_b",  data_b, {4{32'h5555_5555}});
    check_output("col_err_b",   128'(err_b), 128'h0);
    tick();
    check_output("col_valid_a", 128'(valid_a), 128'h3);
    check_output("col_data_a",  128'(data_a), 128'({2{32'h5555_5555}}));
    check_output("col_err_a",   128'(err_a), 128'h0);
    check_output("hold_valid_b", 128'(valid_b), 128'h0);
    check_output("hold_data_b",  data_b, {4{32'h5555_5555}});
    req_a = 2'b11; addr_a = {32'h10, 32'h20};
    req_b = 4'b0011; addr_b[63:0] = {32'h10, 32'h20};
    tick();
    req_a = '0; req_b = '0;
    check_output("stored_valid_b", 128'(valid_b), 128'h3);
    check_output("stored_data_b",  data_b, {32'h5555_5555, 32'h5555_5555, 32'h13, 32'h5555_5555});
    tick();
    check_output("stored_data_a",  128'(data_a), 128'({32'h13, 32'h5555_5555}));

    // Fill words 0..15, then stream back-to-back reads
    $display("[TB] streaming");
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i * 4); wr_data = fill_word(i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        req_a = 2'b11; req_b = 4'b1111;
        for (int k = 0; k < 2; k++) addr_a[k*32 +: 32] = 32'(((c + k) % 16) * 4);
        for (int k = 0; k < 4; k++) addr_b[k*32 +: 32] = 32'(((c + k) % 16) * 4);
      end else begin
        req_a = '0; req_b = '0;
      end
      tick();
      if (c < 16) begin
        for (int k = 0; k < 4; k++) exp_b[k*32 +: 32] = fill_word((c + k) % 16);
        check_output("str_valid_b", 128'(valid_b), 128'hF);
        check_output("str_data_b",  data_b, exp_b);
      end else begin
        check_output("str_end_b", 128'(valid_b), 128'h0);
      end
      if (c >= 1) begin
        for (int k = 0; k < 2; k++) exp_a[k*32 +: 32] = fill_word((c - 1 + k) % 16);
        check_output("str_valid_a", 128'(valid_a), 128'h3);
        check_output("str_data_a",  128'(data_a), 128'(exp_a));
      end else begin
        check_output("str_start_a", 128'(valid_a), 128'h0);
      end
    end
    tick();
    check_output("str_end_a", 128'(valid_a), 128'h0);

    // Reset with reads in flight
    $display("[TB] reset in flight");
    req_a = 2'b11; addr_a = {32'h4, 32'h0};
    req_b = 4'b0011; addr_b[63:0] = {32'h4, 32'h0};
    tick();
    req_a = '0; req_b = '0;
    rst = 1'b1;
    #1;
    check_output("rif_valid_a", 128'(valid_a), 128'h0);
    check_output("rif_data_a",  128'(data_a),  128'h0);
    check_output("rif_valid_b", 128'(valid_b), 128'h0);
    check_output("rif_data_b",  data_b,        128'h0);
    tick();
    rst = 1'b0;
    tick();
    check_output("rif_drop_a",  128'(valid_a), 128'h0);
    check_output("rif_err_a",   128'(err_a),   128'h0);
    check_output("rif_zero_a",  128'(data_a),  128'h0);
    req_a = 2'b01; addr_a[31:0] = 32'h10;
    req_b = 4'b0001; addr_b[31:0] = 32'h10;
    tick();
    req_a = '0; req_b = '0;
    check_output("post_valid_b", 128'(valid_b), 128'h1);
    check_output("post_data_b",  data_b, {96'h0, fill_word(4)});
    tick();
    check_output("post_valid_a", 128'(valid_a), 128'h1);
    check_output("post_data_a",  128'(data_a), 128'({32'h0, fill_word(4)}));
    check_output("post_err_a",   128'(err_a), 128'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mp.md
INSTR_FETCH_MP -- requirements
Module: instr_fetch_mp

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter DEPTH_LOG2, default 10, log2 of memory depth in words.
REQ-004 Parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-005 Parameter IN_REG, default 1, 1 = registered input stage on all ports, 0 = none.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 wr_en  in  1  write strobe.
REQ-009 wr_addr  in  ADDR_WIDTH  write byte address.
REQ-010 wr_data  in  DATA_WIDTH  write word.
REQ-011 rd_req  in  NUM_RD  per-port read request.
REQ-012 rd_addr  in  NUM_RD*ADDR_WIDTH  per-port byte address, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-013 rd_valid  out  NUM_RD  per-port response valid, one-cycle pulse per request.
REQ-014 rd_data  out  NUM_RD*DATA_WIDTH  per-port instruction word, same packing as rd_addr.
REQ-015 rd_err  out  NUM_RD  per-port error flag, qualified by rd_valid.

Function
REQ-016 Word index SHALL be addr[DEPTH_LOG2+1:2]; an address is legal iff addr[1:0]==0 and addr[ADDR_WIDTH-1:DEPTH_LOG2+2]==0.
REQ-017 Write with wr_en=1 and legal wr_addr SHALL update the word at the next rising edge; illegal write SHALL be silently dropped.
REQ-018 Read latency from rd_req sampled high to rd_valid high SHALL be 1+IN_REG cycles, fixed, for every port.
REQ-019 All NUM_RD ports SHALL be served every cycle, no arbitration, no stall, fully pipelined (one request per port per cycle).
REQ-020 Legal read SHALL return rd_err=0 and the stored word.
REQ-021 Illegal read SHALL return rd_err=1 and rd_data=0, memory not accessed.
REQ-022 Read and write to the same word at the memory-access edge SHALL return the new write data (write-first forwarding), per port independently.
REQ-023 With IN_REG=1, write is also registered, so write and read issued on the same input cycle SHALL collide at the same memory-access edge and obey REQ-022.
REQ-024 When rd_valid=0 the port's rd_data and rd_err SHALL hold their last values.
REQ-025 rd_req=0 SHALL produce no rd_valid pulse; address on that cycle is don't-care.

Reset
REQ-026 While rst=1: rd_valid=0, rd_err=0, rd_data=0 on all ports, all input-stage registers 0.
REQ-027 Requests in flight when rst asserts SHALL be discarded; no rd_valid for them after deassert.
REQ-028 Memory contents SHALL NOT be reset; first legal read after reset of an unwritten word returns undefined data with rd_err=0.
REQ-029 A write in flight (registered, not yet performed) when rst asserts SHALL be dropped.

Structure
REQ-030 Package instr_fetch_pkg SHALL hold default width/depth constants and the legality-check function shared with instr_fetch.
REQ-031 One sub-module instr_fetch_rd_port SHALL implement a single port's optional input register, legality check, forwarding compare and output register; instantiated NUM_RD times by generate.
REQ-032 Memory array and write path SHALL live in the top module; reads are combinational array taps feeding each port's output register.

Verification
REQ-033 Reset then write 0x00000013 to 0x10, read port0 0x10 two cycles later -> rd_valid0 after 1+IN_REG cycles, rd_data0=0x00000013, rd_err0=0.
REQ-034 Port0 reads 0x12, port1 reads 0x00001000 (DEPTH_LOG2=10) -> both rd_err=1, rd_data=0, memory unchanged.
REQ-035 Word 0x20 holds 0xAAAAAAAA; same cycle write 0x55555555 to 0x20 and read 0x20 on both ports -> both return 0x55555555.
REQ-036 Back-to-back reads on all ports to 0x0,0x4,0x8,... for 16 cycles -> 16 consecutive rd_valid pulses per port, data in order, no gaps.
REQ-037 Assert rst with 2 reads in flight, release after 1 cycle -> no rd_valid for them, outputs 0; subsequent read of previously written word returns correct data.
REQ-038 Repeat REQ-033..037 for IN_REG=0 and NUM_RD=1,4 -> latency 1, all ports correct.
